alu_ctrl_issue: RTL and testbench

Registered ALU control decode-and-issue stage, successor to the combinational ALU control decoder. It sits at the ID/EX boundary and takes op, funct3, full funct7 and the ALUOp class from the main decoder. It emits a widened ALU control code with a valid/ready handshake, flush support, and optional RV32M decode. M-extension ops hold the stage for a parametrised occupancy time that models the iterative mul/div unit.

---
 rtl/alu_ctrl_pkg.sv | 64 ++++++
 rtl/alu_ctrl_decode.sv | 70 +++++++
 rtl/alu_ctrl_issue.sv | 147 ++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU control codes, ALUOp classes, opcode/funct7 constants
// and the issue-stage FSM state type.
package alu_ctrl_pkg;

  localparam int unsigned CodeW = 5;
  typedef logic [CodeW-1:0] code_t;

  // Base integer ops
  localparam code_t CTRL_ADD    = 5'b00000;
  localparam code_t CTRL_SUB    = 5'b00001;
  localparam code_t CTRL_AND    = 5'b00010;
  localparam code_t CTRL_OR     = 5'b00011;
  localparam code_t CTRL_XOR    = 5'b00100;
  localparam code_t CTRL_SLL    = 5'b00101;
  localparam code_t CTRL_SRL    = 5'b00110;
  localparam code_t CTRL_SRA    = 5'b00111;
  localparam code_t CTRL_SLTU   = 5'b01000;
  localparam code_t CTRL_SLT    = 5'b01001;

  // M-extension ops
  localparam code_t CTRL_MUL    = 5'b10000;
  localparam code_t CTRL_MULH   = 5'b10001;
  localparam code_t CTRL_MULHSU = 5'b10010;
  localparam code_t CTRL_MULHU  = 5'b10011;
  localparam code_t CTRL_DIV    = 5'b10100;
  localparam code_t CTRL_DIVU   = 5'b10101;
  localparam code_t CTRL_REM    = 5'b10110;
  localparam code_t CTRL_REMU   = 5'b10111;

  // ALUOp classes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StWait
  } state_e;

  // Control code of an M-extension op selected by funct3.
  function automatic code_t mext_code(input logic [2:0] funct3);
    code_t c;
    unique case (funct3)
      3'b000:  c = CTRL_MUL;
      3'b001:  c = CTRL_MULH;
      3'b010:  c = CTRL_MULHSU;
      3'b011:  c = CTRL_MULHU;
      3'b100:  c = CTRL_DIV;
      3'b101:  c = CTRL_DIVU;
      3'b110:  c = CTRL_REM;
      default: c = CTRL_REMU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU control decode from op/funct3/funct7/ALUOp.
// Optional macro RV_MEXT_EN enables RV32M decode; without it, funct7=0000001 on an
// R-type is flagged illegal and decodes as the base op.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [1:0]       alu_op_i,
  output logic [CodeW-1:0] code_o,
  output logic             is_muldiv_o,
  output logic             illegal_o
);

  logic  is_rtype;
  logic  f7_known;
  logic  mext_op;
  code_t base_code;

  assign is_rtype = (op_i == OP_RTYPE);

`ifdef RV_MEXT_EN
  assign mext_op  = is_rtype & (funct7_i == F7_MEXT);
  assign f7_known = (funct7_i == F7_BASE) | (funct7_i == F7_ALT) | (funct7_i == F7_MEXT);
`else
  assign mext_op  = 1'b0;
  assign f7_known = (funct7_i == F7_BASE) | (funct7_i == F7_ALT);
`endif

  // Base integer op selected by funct3, with the funct7[5] alternates.
  always_comb begin
    base_code = CTRL_ADD;
    unique case (funct3_i)
      3'b000:  base_code = (op_i[5] & funct7_i[5]) ? CTRL_SUB : CTRL_ADD;
      3'b001:  base_code = CTRL_SLL;
      3'b010:  base_code = CTRL_SLT;
      3'b011:  base_code = CTRL_SLTU;
      3'b100:  base_code = CTRL_XOR;
      3'b101:  base_code = funct7_i[5] ? CTRL_SRA : CTRL_SRL;
      3'b110:  base_code = CTRL_OR;
      default: base_code = CTRL_AND;
    endcase
  end

  // Final code by ALUOp class; unknown R-type funct7 is illegal in any class.
  always_comb begin
    code_o      = CTRL_ADD;
    is_muldiv_o = 1'b0;
    illegal_o   = is_rtype & ~f7_known;
    unique case (alu_op_i)
      ALUOP_ADD: code_o = CTRL_ADD;
      ALUOP_SUB: code_o = CTRL_SUB;
      ALUOP_FUNCT: begin
        if (mext_op) begin
          code_o      = mext_code(funct3_i);
          is_muldiv_o = 1'b1;
        end else begin
          code_o = base_code;
        end
      end
      ALUOP_RSVD: begin
        code_o    = CTRL_ADD;
        illegal_o = 1'b1;
      end
      default: code_o = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: registered ALU control decode-and-issue stage at ID/EX with a
// valid/ready handshake and flush. Optional macro RV_MEXT_EN adds RV32M decode and
// a WAIT state that holds the stage MULDIV_LAT cycles per M op.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W     = 5,
  parameter int unsigned MULDIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              is_muldiv,
  output logic              busy,
  output logic              illegal
);

  logic [CodeW-1:0]  dec_code;
  logic              dec_muldiv;
  logic              dec_illegal;
  logic              accept;
  logic              go_wait;
  logic              wait_done;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;

  alu_ctrl_decode u_decode (
    .op_i        (op),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .alu_op_i    (alu_op),
    .code_o      (dec_code),
    .is_muldiv_o (dec_muldiv),
    .illegal_o   (dec_illegal)
  );

  assign in_ready = ~flush & (state_q != StWait) & ((state_q == StEmpty) | out_ready);
  assign accept   = in_valid & in_ready;

`ifdef RV_MEXT_EN
  localparam int unsigned     CNT_W   = $clog2(MULDIV_LAT + 1);
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam bit              LongOp  = (MULDIV_LAT > 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             muldiv_q, muldiv_d;
  logic             busy_q, busy_d;

  // A single-cycle M unit issues like a base op.
  assign go_wait   = dec_muldiv & LongOp;
  assign wait_done = (cnt_q == CntOne);
  assign busy_d    = (state_d == StWait);

  // Occupancy counter: loaded on M accept, counts down while waiting.
  always_comb begin
    cnt_d    = cnt_q;
    muldiv_d = muldiv_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d    = go_wait ? CntLoad : '0;
      muldiv_d = dec_muldiv;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // M-op state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      muldiv_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      muldiv_q <= muldiv_d;
      busy_q   <= busy_d;
    end
  end

  assign is_muldiv = muldiv_q;
  assign busy      = busy_q;
`else
  logic unused_nomext;

  assign go_wait       = 1'b0;
  assign wait_done     = 1'b0;
  assign unused_nomext = dec_muldiv ^ (MULDIV_LAT != 0);
  assign is_muldiv     = 1'b0;
  assign busy          = 1'b0;
`endif

  // Issue FSM next state and output payload; flush wins over accept.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      ctrl_d    = CTRL_W'(dec_code);
      illegal_d = dec_illegal;
      state_d   = go_wait ? StWait : StFull;
    end else begin
      unique case (state_q)
        StFull:  if (out_ready) state_d = StEmpty;
        StWait:  if (wait_done) state_d = StFull;
        default: state_d = state_q;
      endcase
    end
  end

  assign out_valid_d = (state_d == StFull);

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed and randomized stimulus; a scoreboard queue of
// expected issues (with the cycle they become visible) is checked by a monitor.
module tb_alu_ctrl_issue;

  localparam int unsigned CTRL_W = 6;
  localparam int unsigned LAT    = 8;
`ifdef RV_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  // funct3 -> base op code
  localparam logic [4:0] BASE_TAB [8] = '{5'd0, 5'd5, 5'd9, 5'd8, 5'd4, 5'd6, 5'd3, 5'd2};

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, out_ready;
  logic [6:0]        op, funct7;
  logic [2:0]        funct3;
  logic [1:0]        alu_op;
  logic              in_ready, out_valid, is_muldiv, busy, illegal;
  logic [CTRL_W-1:0] alu_ctrl;

  always #5 clk = ~clk;

  alu_ctrl_issue #(
    .CTRL_W     (CTRL_W),
    .MULDIV_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .is_muldiv (is_muldiv),
    .busy      (busy),
    .illegal   (illegal)
  );

  typedef struct {
    logic [CTRL_W-1:0] code;
    logic              md;
    logic              ill;
    int                rdy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   exp_in_ready = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode straight from the op tables.
  function automatic exp_t ref_model(input logic [6:0] o, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [1:0] aop);
    exp_t       e;
    logic [4:0] c;
    bit         rtype;
    bit         f7_ok;
    rtype = (o == 7'b0110011);
    f7_ok = (f7 == 7'h00) || (f7 == 7'h20) || (MEXT && f7 == 7'h01);
    e.ill = (rtype && !f7_ok) || (aop == 2'b11);
    e.md  = 1'b0;
    c     = 5'd0;
    if (aop == 2'b01) c = 5'd1;
    if (aop == 2'b10) begin
      if (MEXT && rtype && f7 == 7'h01) begin
        c    = 5'b10000 | {2'b00, f3};
        e.md = 1'b1;
      end else begin
        c = BASE_TAB[f3];
        if (f3 == 3'd0 && o[5] && f7[5]) c = 5'd1;
        if (f3 == 3'd5 && f7[5]) c = 5'd7;
      end
    end
    e.code = CTRL_W'(c);
    e.rdy  = 0;
    return e;
  endfunction

  // One clock: update the model with the inputs seen at this edge, then settle.
  task automatic step();
    exp_t e;
    int   lat;
    @(posedge clk);
    cyc++;
    if (!rst_n || flush) begin
      sb_q.delete();
    end else if (in_valid && exp_in_ready) begin
      e     = ref_model(op, funct3, funct7, alu_op);
      lat   = (e.md && LAT > 1) ? LAT : 1;
      e.rdy = cyc + lat - 1;
      sb_q.push_back(e);
    end
    #1;
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [1:0] aop);
    in_valid = 1'b1;
    op       = o;
    funct3   = f3;
    funct7   = f7;
    alu_op   = aop;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare DUT handshake/outputs with the scoreboard head.
  always @(negedge clk) begin
    bit ev;
    bit ew;
    ev = (sb_q.size() > 0) && (cyc >= sb_q[0].rdy);
    ew = (sb_q.size() > 0) && (cyc < sb_q[0].rdy);
    exp_in_ready = !flush && !ew && ((sb_q.size() == 0) || out_ready);
    if (mon_en) begin
      chk("mon_out_valid", 32'(out_valid), 32'(ev));
      chk("mon_busy", 32'(busy), 32'(ew));
      chk("mon_in_ready", 32'(in_ready), 32'(exp_in_ready));
      if (ev && out_valid) begin
        chk("mon_alu_ctrl", 32'(alu_ctrl), 32'(sb_q[0].code));
        chk("mon_is_muldiv", 32'(is_muldiv), 32'(sb_q[0].md));
        chk("mon_illegal", 32'(illegal), 32'(sb_q[0].ill));
      end
    end
    if (ev && out_ready && !flush && rst_n) void'(sb_q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cnt;
    int vcnt;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    issue(7'b0110011, 3'b000, 7'h20, 2'b10);

    // Reset with in_valid high
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_is_muldiv", 32'(is_muldiv), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    mon_en   = 1'b1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // SUB then SRA back-to-back
    issue(7'b0110011, 3'b000, 7'h20, 2'b10);
    step();
    chk("b2b_sub_valid", 32'(out_valid), 32'd1);
    chk("b2b_sub_code", 32'(alu_ctrl), 32'd1);
    issue(7'b0110011, 3'b101, 7'h20, 2'b10);
    step();
    chk("b2b_sra_valid", 32'(out_valid), 32'd1);
    chk("b2b_sra_code", 32'(alu_ctrl), 32'd7);
    idle(2);

    // DIV latency and occupancy
    issue(7'b0110011, 3'b100, 7'h01, 2'b10);
    step();
    in_valid = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (!out_valid && n < 20) begin
      if (busy) busy_cnt++;
      step();
      n++;
    end
    chk("div_latency", 32'(n), MEXT ? 32'(LAT) : 32'd1);
    chk("div_busy_cycles", 32'(busy_cnt), MEXT ? 32'(LAT - 1) : 32'd0);
    chk("div_code", 32'(alu_ctrl), MEXT ? 32'd20 : 32'd4);
    chk("div_is_muldiv", 32'(is_muldiv), 32'(MEXT));
    chk("div_illegal", 32'(illegal), 32'(!MEXT));
    idle(2);

    // Backpressure on XOR, a pending ADD waits
    out_ready = 1'b0;
    issue(7'b0110011, 3'b100, 7'h00, 2'b10);
    step();
    issue(7'b0110011, 3'b000, 7'h00, 2'b10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_code", 32'(alu_ctrl), 32'd4);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_next_code", 32'(alu_ctrl), 32'd0);
    idle(2);

    // Flush during MUL occupancy
    issue(7'b0110011, 3'b000, 7'h01, 2'b10);
    vcnt = 0;
    step();
    in_valid = 1'b0;
    if (out_valid) vcnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      if (out_valid) vcnt++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) vcnt++;
    end
    chk("flush_mul_valid_cycles", 32'(vcnt), MEXT ? 32'd0 : 32'd1);
    issue(7'b0010011, 3'b000, 7'h00, 2'b00);
    step();
    in_valid = 1'b0;
    chk("flush_add_valid", 32'(out_valid), 32'd1);
    chk("flush_add_code", 32'(alu_ctrl), 32'd0);
    idle(2);

    // Illegal classes
    issue(7'b0110011, 3'b011, 7'h00, 2'b11);
    step();
    in_valid = 1'b0;
    chk("rsvd_code", 32'(alu_ctrl), 32'd0);
    chk("rsvd_illegal", 32'(illegal), 32'd1);
    idle(1);
    issue(7'b0110011, 3'b110, 7'h01, 2'b10);
    step();
    in_valid = 1'b0;
    chk("f7m_code", 32'(alu_ctrl), MEXT ? 32'd22 : 32'd3);
    chk("f7m_illegal", 32'(illegal), 32'(!MEXT));
    chk("f7m_is_muldiv", 32'(is_muldiv), 32'(MEXT));
    idle(MEXT ? LAT + 2 : 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 3))
        0, 1:    op = 7'b0110011;
        2:       op = 7'b0010011;
        default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       funct7 = 7'h00;
        1:       funct7 = 7'h20;
        2:       funct7 = 7'h01;
        default: funct7 = 7'($urandom);
      endcase
      funct3 = 3'($urandom);
      alu_op = ($urandom_range(0, 7) < 5) ? 2'b10 : 2'($urandom);
      step();
    end
    flush = 1'b0;
    rst_n = 1'b1;
    idle(LAT + 4);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
